uart_tx_8n1: RTL and testbench
==============================

Name: uart_tx_8n1

Overview:
UART/RS-232 serial transmitter. Accepts a parallel byte with a single-cycle start strobe and shifts it out LSB-first on one serial line, framed with a start bit and stop bit(s). Bit timing comes from an external baud-rate generator that pulses `baud_tick`. It sits between the host-side byte source and the line driver of the UART block.

Parameters:
- PARITY_EN, 0: 1 inserts a parity bit between the last data bit and the stop bit(s); 0 gives no parity (8N1).
- PARITY_ODD, 0: applies only when PARITY_EN=1; 0 selects even parity, 1 selects odd parity.
- STOP_BITS, 1: number of stop bits, either 1 or 2; any other value is illegal.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- baud_tick  in  1  one-clk-wide enable pulse, once per bit period.
- tx_data  in  8  byte to send; sampled only on acceptance.
- tx_start  in  1  request strobe; sampled every clk.
- tx_busy  out  1  high while a frame is pending or on the line.
- tx_out  out  1  serial line; idle/mark is 1.

Behaviour:
- Clocking and reset: one clock domain, `clk`. Reset is synchronous and active-low: `rst_n`=0 at a rising `clk` edge forces state IDLE, `tx_out`=1, `tx_busy`=0, and clears the shift register and bit counter. Reset has priority over all other inputs, including mid-frame; the frame is aborted and the line returns to 1 on that edge.
- Outputs are registered; there are no combinational input-to-output paths.
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - `tx_out`=1, `tx_busy`=0.
  - On an edge with `tx_start`=1, latch `tx_data` into the shift register, set `tx_busy`=1 (visible one cycle later) and go to WAIT.
- WAIT: `tx_out` stays 1. On the next `baud_tick`, drive `tx_out`=0 and go to START. A `baud_tick` coincident with the acceptance edge does not count.
  - Result: the start bit is aligned to the tick grid.
  - Latency from acceptance to the falling edge of `tx_out` is 1 to one full tick period.
- START → DATA: on `baud_tick`, drive data bit 0 (LSB).
- DATA:
  - Each `baud_tick` advances to the next bit; a 3-bit counter tracks bits 0..7.
  - After bit 7's period: go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: drives the XOR of the 8 latched bits, inverted when PARITY_ODD=1. The next `baud_tick` goes to STOP.
- STOP:
  - `tx_out`=1 for STOP_BITS tick periods.
  - On the `baud_tick` ending the last stop bit, go to IDLE with `tx_busy`=0 on that edge.
  - No idle gap is inserted beyond the stop bit(s).
- Every bit (start, data, parity, stop) lasts exactly one `baud_tick` interval, measured tick-to-tick.
- `tx_busy` is 1 continuously from the cycle after acceptance through the end of the last stop bit.
- `tx_start` while `tx_busy`=1 is ignored: not queued, with no effect on the frame in flight.
- `tx_start` held high through the return to IDLE is accepted on the first IDLE edge, giving back-to-back frames.
- `tx_data` changes after acceptance do not affect the frame in flight.
- Frame length (8N1) is 10 bit periods plus the WAIT alignment.

Test Plan:
- Reset and idle, with the tick every 5 clk: hold `rst_n`=0 for 10 clk, then release. Required: `tx_out`=1 and `tx_busy`=0 throughout; `tx_start`=0 produces no activity.
- Single byte 0xA5: pulse `tx_start` for 1 clk. Required:
  - `tx_busy` rises the next cycle.
  - Line sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit held 5 clk.
  - `tx_busy` falls at the end of the stop bit; total busy time 50–55 clk.
- Back-to-back frames 0x00, 0xFF, 0x3C, each sent after `tx_busy` falls. Required:
  - 0x00 gives start plus 8 zeros, then 1.
  - 0xFF gives 0 then nine 1s.
  - 0x3C gives 0,0,0,1,1,1,1,0,0,1.
- Start during busy: send 0x77, then 25 clk later pulse `tx_start` with 0xB2. Required: the line carries only the 0x77 frame; no 0xB2 frame follows; `tx_busy` falls once.
- Reset mid-frame: assert `rst_n`=0 during data bit 3. Required: `tx_out`=1 and `tx_busy`=0 on the next edge; a new 0x5A sent afterwards is correct.
- Parity/stop variant with PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2: send 0x07. Required: parity bit 1 after bit 7, then two stop bits of 1; busy for 12 ticks plus the WAIT alignment.

Source files
------------

// File: rtl/uart_tx_8n1.sv
// UART serial transmitter: one byte per frame, LSB first, start bit,
// optional parity bit and one or two stop bits. Bit timing comes from an
// external baud_tick enable; the start bit is aligned to the tick grid.
module uart_tx_8n1 #(
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Index of the final stop bit; STOP_BITS is restricted to 1 or 2.
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t     state_q,    state_d;
  logic [7:0] shreg_q,    shreg_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       tx_out_q,   tx_out_d;
  logic       tx_busy_q,  tx_busy_d;
  logic       parity_bit;

  // The byte is held unshifted so parity can be taken over all 8 bits.
  assign parity_bit = (^shreg_q) ^ (PARITY_ODD != 0);

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_out_q   <= tx_out_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Next-state logic; tx_out_d is the level the line takes for the next bit.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_out_d   = tx_out_q;
    tx_busy_d  = tx_busy_q;
    unique case (state_q)
      S_IDLE: begin
        tx_out_d  = 1'b1;
        tx_busy_d = 1'b0;
        if (tx_start) begin
          shreg_d    = tx_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_busy_d  = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (baud_tick) begin
          tx_out_d = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_out_d  = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              tx_out_d = parity_bit;
              state_d  = S_PARITY;
            end else begin
              tx_out_d   = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_out_d  = shreg_q[bit_cnt_d];
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_out_d   = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        tx_out_d = 1'b1;
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            tx_busy_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_out_d  = 1'b1;
        tx_busy_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Testbench for uart_tx_8n1: an 8N1 instance and an even-parity, two-stop
// instance share clock, reset, tick and data. Expected line levels come from
// a frame model built directly from the framing rules.
module tb_uart_tx_8n1;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_start_p;
  logic       tx_busy;
  logic       tx_out;
  logic       tx_busy_p;
  logic       tx_out_p;

  int passed = 0;
  int total  = 0;
  int cyc;
  int bc;
  bit exp_q[$];

  uart_tx_8n1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_out    (tx_out)
  );

  uart_tx_8n1 #(
    .PARITY_EN  (1),
    .PARITY_ODD (0),
    .STOP_BITS  (2)
  ) dut_p (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .tx_data   (tx_data),
    .tx_start  (tx_start_p),
    .tx_busy   (tx_busy_p),
    .tx_out    (tx_out_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick every 5 clk, driven on the falling edge.
  initial begin
    int ph;
    ph = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = (ph == 4);
      ph = (ph + 1) % 5;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
  endtask

  function automatic logic out_of(input bit sel);
    return sel ? tx_out_p : tx_out;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? tx_busy_p : tx_busy;
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) tx_start_p = v;
    else     tx_start   = v;
  endtask

  // Frame model: start 0, data LSB first, optional parity, stop bits of 1.
  task automatic build_frame(input bit sel, input logic [7:0] b);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      if (b[i]) ones++;
    end
    if (sel) exp_q.push_back((ones % 2) == 1);   // even parity
    exp_q.push_back(1'b1);
    if (sel) exp_q.push_back(1'b1);
  endtask

  task automatic step(input bit sel, input int inj_at, input logic [7:0] inj_b);
    @(negedge clk);
    cyc++;
    if (cyc == inj_at) begin
      drive(sel, 1'b1);
      tx_data = inj_b;
    end else begin
      drive(sel, 1'b0);
    end
    if (busy_of(sel) === 1'b1) bc++;
  endtask

  // Send one byte and check every clock of the frame against the model.
  task automatic check_frame(input bit sel, input logic [7:0] b,
                             input int inj_at, input logic [7:0] inj_b);
    int n;
    build_frame(sel, b);
    n = exp_q.size();
    @(negedge clk);
    tx_data = b;
    drive(sel, 1'b1);
    cyc = 0;
    bc  = 0;
    step(sel, inj_at, inj_b);
    tx_data = 8'($urandom);
    chk("busy_rise", busy_of(sel), 1);
    while (out_of(sel) !== 1'b0 && cyc < 8) step(sel, inj_at, inj_b);
    chk("start_edge", out_of(sel), 0);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 5; j++) begin
        if (k != 0 || j != 0) step(sel, inj_at, inj_b);
        chk($sformatf("bit%0d_b%02h", k, b), out_of(sel), exp_q[k]);
      end
    end
    step(sel, inj_at, inj_b);
    chk("busy_fall", busy_of(sel), 0);
    chk("idle_line", out_of(sel), 1);
    chk("busy_len", (bc >= 5 * n && bc <= 5 * n + 5), 1);
    drive(sel, 1'b0);
  endtask

  initial begin
    int bad;
    logic [7:0] rb;
    rst_n      = 1'b0;
    tx_data    = 8'h00;
    tx_start   = 1'b0;
    tx_start_p = 1'b0;

    // Reset held for 10 clk, then idle with no start.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_out", tx_out, 1);
      chk("rst_busy", tx_busy, 0);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_out_p !== 1'b1 || tx_busy_p !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Directed frames.
    check_frame(1'b0, 8'hA5, -1, 8'h00);
    check_frame(1'b0, 8'h00, -1, 8'h00);
    check_frame(1'b0, 8'hFF, -1, 8'h00);
    check_frame(1'b0, 8'h3C, -1, 8'h00);

    // Start during busy is ignored and not queued.
    check_frame(1'b0, 8'h77, 25, 8'hB2);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("no_queued_frame", bad, 0);

    // Reset during data bit 3.
    @(negedge clk);
    tx_data = 8'h33;
    tx_start = 1'b1;
    cyc = 0;
    bc  = 0;
    step(1'b0, -1, 8'h00);
    while (tx_out !== 1'b0 && cyc < 8) step(1'b0, -1, 8'h00);
    chk("mid_start_edge", tx_out, 0);
    for (int i = 0; i < 22; i++) step(1'b0, -1, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", tx_out, 1);
    chk("mid_rst_busy", tx_busy, 0);
    rst_n = 1'b1;
    check_frame(1'b0, 8'h5A, -1, 8'h00);

    // Parity and two stop bits.
    check_frame(1'b1, 8'h07, -1, 8'h00);

    // Randomized bytes and start phases on both variants.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      repeat ($urandom_range(0, 7)) @(negedge clk);
      check_frame(i[0], rb, -1, 8'h00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
